// File: rtl/sfp_seq.sv
// Row sequencer for sfp_row: reads one psum row, strobes accumulate/divide,
// then writes the normalized result to the output SRAM, once per row.
module sfp_seq #(
  parameter int col     = 8,
  parameter int bw_psum = 19,
  parameter int bw_out  = 9,
  parameter int aw      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [aw:0]             n_rows,
  output logic                    psum_cen,
  output logic [aw-1:0]           psum_addr,
  input  logic [col*bw_psum-1:0]  psum_q,
  output logic [col*bw_psum-1:0]  sfp_in,
  output logic                    acc,
  output logic                    div,
  output logic                    fifo_ext_rd,
  input  logic [col*bw_out-1:0]   sfp_out,
  output logic                    out_cen,
  output logic                    out_wen,
  output logic [aw-1:0]           out_addr,
  output logic [col*bw_out-1:0]   out_d,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD   = 4'd1,
    LOAD = 4'd2,
    ACC1 = 4'd3,
    ACC2 = 4'd4,
    GAP  = 4'd5,
    DIV1 = 4'd6,
    DIV2 = 4'd7,
    W1   = 4'd8,
    W2   = 4'd9,
    WR   = 4'd10,
    DONE = 4'd11
  } state_t;

  localparam logic [aw:0] MAX_ROWS = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] ONE_ROW  = {{aw{1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [aw-1:0]            row_q, row_d;
  logic [aw:0]              nrows_q, nrows_d;
  logic [col*bw_psum-1:0]   sfp_in_q, sfp_in_d;

  // state, row counter, latched row count and held psum row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      nrows_q  <= '0;
      sfp_in_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      nrows_q  <= nrows_d;
      sfp_in_q <= sfp_in_d;
    end
  end

  // next-state and per-state output decode
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    nrows_d     = nrows_q;
    sfp_in_d    = sfp_in_q;
    psum_cen    = 1'b1;
    psum_addr   = '0;
    acc         = 1'b0;
    div         = 1'b0;
    out_cen     = 1'b1;
    out_wen     = 1'b1;
    out_addr    = '0;
    out_d       = '0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // counts beyond the SRAM depth are clamped so addresses never wrap
          nrows_d = (n_rows > MAX_ROWS) ? MAX_ROWS : n_rows;
          row_d   = '0;
          state_d = (n_rows != '0) ? RD : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        psum_cen  = 1'b0;
        psum_addr = row_q;
        state_d   = LOAD;
      end
      LOAD: begin
        sfp_in_d = psum_q;
        state_d  = ACC1;
      end
      ACC1: begin
        acc     = 1'b1;
        state_d = ACC2;
      end
      ACC2: begin
        acc     = 1'b1;
        state_d = GAP;
      end
      GAP:  state_d = DIV1;
      DIV1: begin
        div     = 1'b1;
        state_d = DIV2;
      end
      DIV2: begin
        div     = 1'b1;
        state_d = W1;
      end
      W1:   state_d = W2;
      W2:   state_d = WR;
      WR: begin
        out_cen  = 1'b0;
        out_wen  = 1'b0;
        out_addr = row_q;
        out_d    = sfp_out;
        if ({1'b0, row_q} == (nrows_q - ONE_ROW)) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + {{(aw-1){1'b0}}, 1'b1};
          state_d = RD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign sfp_in      = sfp_in_q;
  assign fifo_ext_rd = 1'b0;

endmodule

// File: tb/tb_sfp_seq.sv
// Directed bench for sfp_seq with a behavioural psum SRAM and a simple
// stand-in for sfp_row (lane-wise low 9 bits xor 9'h0A5).
module tb_sfp_seq;
  localparam int COL = 8;
  localparam int BWP = 19;
  localparam int BWO = 9;
  localparam int AW  = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [AW:0]          n_rows = '0;
  logic                 psum_cen;
  logic [AW-1:0]        psum_addr;
  logic [COL*BWP-1:0]   psum_q = '0;
  logic [COL*BWP-1:0]   sfp_in;
  logic                 acc, div, fifo_ext_rd;
  logic [COL*BWO-1:0]   sfp_out;
  logic                 out_cen, out_wen;
  logic [AW-1:0]        out_addr;
  logic [COL*BWO-1:0]   out_d;
  logic                 busy, done;

  int total = 0;
  int bad   = 0;

  logic [COL*BWP-1:0] psum_mem [0:15];

  // observation log filled by run_op
  int                 done_cyc, wr_cnt, psum_lo, cyc;
  bit                 timeout, busy_after;
  logic [63:0]        acc_m, div_m, busy_m, pcen_m, ocen_m;
  logic [AW-1:0]      wr_addr [0:31];
  logic [COL*BWO-1:0] wr_data [0:31];
  logic [COL*BWP-1:0] hist [0:15];
  logic [7:0]         snap_ctl;
  logic [COL*BWP-1:0] snap_sfp;
  logic [COL*BWO-1:0] snap_outd;
  logic [2*AW-1:0]    snap_addr;

  sfp_seq #(.col(COL), .bw_psum(BWP), .bw_out(BWO), .aw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows),
    .psum_cen(psum_cen), .psum_addr(psum_addr), .psum_q(psum_q),
    .sfp_in(sfp_in), .acc(acc), .div(div), .fifo_ext_rd(fifo_ext_rd),
    .sfp_out(sfp_out), .out_cen(out_cen), .out_wen(out_wen),
    .out_addr(out_addr), .out_d(out_d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!psum_cen) psum_q <= psum_mem[psum_addr];
  end

  always_comb begin
    sfp_out = '0;
    for (int i = 0; i < COL; i++) sfp_out[i*BWO +: BWO] = sfp_in[i*BWP +: BWO] ^ 9'h0A5;
  end

  function automatic logic [COL*BWO-1:0] exp_out(input logic [COL*BWP-1:0] row);
    logic [COL*BWO-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BWO +: BWO] = row[i*BWP +: BWO] ^ 9'h0A5;
    return r;
  endfunction

  task automatic take_snap();
    snap_ctl  = {acc, div, fifo_ext_rd, psum_cen, out_cen, out_wen, busy, done};
    snap_sfp  = sfp_in;
    snap_outd = out_d;
    snap_addr = {psum_addr, out_addr};
  endtask

  // start an operation and log per-cycle behaviour; cycle 1 follows the start edge
  task automatic run_op(input logic [AW:0] n, input int s2, input int s3,
                        input int rst_cyc, input int max_cyc);
    done_cyc = 0; wr_cnt = 0; psum_lo = 0; timeout = 1'b0; busy_after = 1'b0;
    acc_m = '0; div_m = '0; busy_m = '0; pcen_m = '0; ocen_m = '0;
    @(negedge clk);
    start = 1'b1; n_rows = n;
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == s2 || cyc == s3) begin start = 1'b1; n_rows = 5'd1; end
      if (cyc < 64) begin
        acc_m[cyc] = acc; div_m[cyc] = div; busy_m[cyc] = busy;
        pcen_m[cyc] = ~psum_cen; ocen_m[cyc] = ~out_cen;
      end
      if (cyc < 16) hist[cyc] = sfp_in;
      if (!psum_cen) psum_lo++;
      if (!out_cen && !out_wen && wr_cnt < 32) begin
        wr_addr[wr_cnt] = out_addr; wr_data[wr_cnt] = out_d; wr_cnt++;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin busy_after = busy; break; end
      if (done && done_cyc == 0) done_cyc = cyc;
      if (cyc == rst_cyc) begin
        reset = 1'b1; #1; take_snap();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        break;
      end
      if (cyc >= max_cyc) begin timeout = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    take_snap();
    total++; if (snap_ctl !== 8'b00011100) begin bad++; $display("FAIL reset_ctl got=%b want=%b", snap_ctl, 8'b00011100); end
    total++; if (snap_sfp !== '0) begin bad++; $display("FAIL reset_sfp_in got=%h want=0", snap_sfp); end
    total++; if (snap_addr !== '0 || snap_outd !== '0) begin bad++; $display("FAIL reset_addr_outd got=%h/%h want=0", snap_addr, snap_outd); end
  endtask

  task automatic test_single_row();
    psum_mem[0] = {8{19'd256}};
    run_op(5'd1, 0, 0, 0, 40);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b want=0", timeout); end
    total++; if (acc_m !== 64'h18) begin bad++; $display("FAIL single_acc got=%h want=%h", acc_m, 64'h18); end
    total++; if (div_m !== 64'hC0) begin bad++; $display("FAIL single_div got=%h want=%h", div_m, 64'hC0); end
    total++; if (pcen_m !== 64'h2) begin bad++; $display("FAIL single_psum_cen got=%h want=%h", pcen_m, 64'h2); end
    total++; if (ocen_m !== 64'h400) begin bad++; $display("FAIL single_out_cen got=%h want=%h", ocen_m, 64'h400); end
    total++; if (busy_m !== 64'hFFE) begin bad++; $display("FAIL single_busy got=%h want=%h", busy_m, 64'hFFE); end
    total++; if (done_cyc !== 11) begin bad++; $display("FAIL single_done got=%0d want=11", done_cyc); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy_after); end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL single_wr_cnt got=%0d want=1", wr_cnt); end
    total++; if (wr_addr[0] !== 4'd0 || wr_data[0] !== {8{9'h1A5}}) begin bad++; $display("FAIL single_write got=%h/%h want=0/%h", wr_addr[0], wr_data[0], {8{9'h1A5}}); end
  endtask

  task automatic test_signed();
    psum_mem[0] = {8{19'h7FF00}};
    run_op(5'd1, 0, 0, 0, 40);
    for (int c = 3; c <= 10; c++) begin
      total++; if (hist[c] !== {8{19'h7FF00}}) begin bad++; $display("FAIL signed_hold cyc=%0d got=%h want=%h", c, hist[c], {8{19'h7FF00}}); end
    end
    total++; if (wr_data[0] !== {8{9'h1A5}}) begin bad++; $display("FAIL signed_write got=%h want=%h", wr_data[0], {8{9'h1A5}}); end
  endtask

  task automatic test_eight_rows();
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < COL; j++) psum_mem[r][j*BWP +: BWP] = 19'(r*37 + j*5 - 20);
    run_op(5'd8, 0, 0, 0, 120);
    total++; if (done_cyc !== 81) begin bad++; $display("FAIL eight_done got=%0d want=81", done_cyc); end
    total++; if (wr_cnt !== 8) begin bad++; $display("FAIL eight_wr_cnt got=%0d want=8", wr_cnt); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (wr_addr[k] !== 4'(k) || wr_data[k] !== exp_out(psum_mem[k])) begin
        bad++; $display("FAIL eight_row%0d got=%h/%h want=%h/%h", k, wr_addr[k], wr_data[k], 4'(k), exp_out(psum_mem[k]));
      end
    end
  endtask

  task automatic test_zero_rows();
    run_op(5'd0, 0, 0, 0, 20);
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done got=%0d want=1", done_cyc); end
    total++; if (psum_lo !== 0 || wr_cnt !== 0) begin bad++; $display("FAIL zero_access got=%0d/%0d want=0/0", psum_lo, wr_cnt); end
    total++; if (busy_m !== 64'h2) begin bad++; $display("FAIL zero_busy got=%h want=%h", busy_m, 64'h2); end
  endtask

  task automatic test_back_to_back();
    run_op(5'd4, 25, 41, 0, 80);
    total++; if (done_cyc !== 41) begin bad++; $display("FAIL busy_start_done got=%0d want=41", done_cyc); end
    total++; if (wr_cnt !== 4) begin bad++; $display("FAIL busy_start_wr_cnt got=%0d want=4", wr_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b want=0", busy_after); end
  endtask

  task automatic test_reset_mid();
    run_op(5'd4, 0, 0, 16, 80);
    total++; if (div_m[16] !== 1'b1) begin bad++; $display("FAIL midrst_in_div1 got=%b want=1", div_m[16]); end
    total++; if (snap_ctl !== 8'b00011100) begin bad++; $display("FAIL midrst_ctl got=%b want=%b", snap_ctl, 8'b00011100); end
    total++; if (snap_sfp !== '0 || snap_addr !== '0 || snap_outd !== '0) begin bad++; $display("FAIL midrst_data got=%h/%h/%h want=0", snap_sfp, snap_addr, snap_outd); end
    total++; if (wr_cnt !== 1 || done_cyc !== 0) begin bad++; $display("FAIL midrst_no_write got=%0d/%0d want=1/0", wr_cnt, done_cyc); end
    run_op(5'd2, 0, 0, 0, 60);
    total++; if (done_cyc !== 21) begin bad++; $display("FAIL midrst_restart_done got=%0d want=21", done_cyc); end
    total++; if (wr_cnt !== 2 || wr_addr[0] !== 4'd0 || wr_addr[1] !== 4'd1) begin bad++; $display("FAIL midrst_restart_wr got=%0d/%h/%h want=2/0/1", wr_cnt, wr_addr[0], wr_addr[1]); end
  endtask

  task automatic test_saturate();
    run_op(5'd20, 0, 0, 0, 220);
    total++; if (done_cyc !== 161) begin bad++; $display("FAIL sat_done got=%0d want=161", done_cyc); end
    total++; if (wr_cnt !== 16) begin bad++; $display("FAIL sat_wr_cnt got=%0d want=16", wr_cnt); end
    total++; if (wr_addr[15] !== 4'd15 || wr_data[15] !== exp_out(psum_mem[15])) begin bad++; $display("FAIL sat_last_row got=%h/%h want=f/%h", wr_addr[15], wr_data[15], exp_out(psum_mem[15])); end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) psum_mem[r] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_single_row();
    test_signed();
    test_eight_rows();
    test_zero_rows();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
